// File: rtl/nec_ir_pkg.sv
// Shared types and timing windows for the NEC IR decoder.
// All windows are in microseconds and compare against the 14-bit
// level-width counter produced by ir_pulse_timer.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } nec_state_t;

  typedef logic [13:0] width_t;

  localparam width_t LEAD_MARK_MIN  = 14'd8000;
  localparam width_t LEAD_MARK_MAX  = 14'd10000;
  localparam width_t LEAD_SPACE_MIN = 14'd4000;
  localparam width_t LEAD_SPACE_MAX = 14'd5000;
  localparam width_t RPT_SPACE_MIN  = 14'd2000;
  localparam width_t RPT_SPACE_MAX  = 14'd2500;
  localparam width_t BIT_MIN        = 14'd400;
  localparam width_t BIT_MAX        = 14'd700;
  localparam width_t ONE_MIN        = 14'd1400;
  localparam width_t ONE_MAX        = 14'd1900;
  localparam width_t TIMEOUT_US     = 14'd12000;
  localparam width_t WIDTH_SAT      = 14'd16383;

  function automatic logic in_window(input width_t w, input width_t lo, input width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Input conditioning and level-width measurement for the IR stream.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   ir_in      : raw receiver pin (idle high, asynchronous)
//   rise, fall : single-cycle synchronised edge strobes (2 cycles after pin)
//   width      : microseconds spent in the current level, saturating;
//                valid as the width of the level that just ended while an
//                edge strobe is high
module ir_pulse_timer
  import nec_ir_pkg::*;
#(
  parameter int CYCLES_PER_US = 50
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ir_in,
  output logic   rise,
  output logic   fall,
  output width_t width
);

  localparam int DIV_W = $clog2(CYCLES_PER_US);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLES_PER_US - 1);

  logic             meta;
  logic             sync;
  logic             prev;
  logic [DIV_W-1:0] div;
  width_t           cnt;

  // Synchroniser flops come out of reset at the idle (high) level so that
  // releasing reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
      div  <= '0;
      cnt  <= '0;
    end else begin
      meta <= ir_in;
      sync <= meta;
      prev <= sync;
      if (rise || fall) begin
        // Restart the sub-tick divider so each level is timed from its edge.
        div <= '0;
        cnt <= '0;
      end else if (div == DIV_LAST) begin
        div <= '0;
        if (cnt != WIDTH_SAT) cnt <= cnt + 14'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;
  assign width = cnt;

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR remote decoder: validates leader, 32 data bits (LSB first) and
// stop mark, then publishes the frame on HEX_DATA.
// Ports:
//   CLK, RESET_N : clock and asynchronous active-low reset
//   IR_IN        : raw receiver output, idle high, mark = low
//   HEX_DATA     : last valid frame {~cmd, cmd, ~addr, addr}
//   DATA_VALID   : one-cycle pulse when HEX_DATA is updated
//   REPEAT       : one-cycle pulse on a valid repeat code
//   FRAME_ERR    : one-cycle pulse on a timing/inversion violation or timeout
module nec_ir_decoder
  import nec_ir_pkg::*;
#(
  parameter int CYCLES_PER_US = 50,
  parameter bit CHECK_CMD_INV = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IR_IN,
  output logic [31:0] HEX_DATA,
  output logic        DATA_VALID,
  output logic        REPEAT,
  output logic        FRAME_ERR
);

  logic       rise;
  logic       fall;
  width_t     width;
  nec_state_t state;
  logic [4:0] bit_cnt;
  logic [31:0] shift;
  logic       rpt;

  ir_pulse_timer #(
    .CYCLES_PER_US(CYCLES_PER_US)
  ) u_timer (
    .clk  (CLK),
    .rst_n(RESET_N),
    .ir_in(IR_IN),
    .rise (rise),
    .fall (fall),
    .width(width)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      rpt        <= 1'b0;
      HEX_DATA   <= '0;
      DATA_VALID <= 1'b0;
      REPEAT     <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      REPEAT     <= 1'b0;
      FRAME_ERR  <= 1'b0;

      if (state != IDLE && !rise && !fall && width >= TIMEOUT_US) begin
        FRAME_ERR <= 1'b1;
        state     <= IDLE;
        shift     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fall) state <= LEAD_MARK;
          end
          LEAD_MARK: begin
            if (rise) begin
              if (in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                state <= LEAD_SPACE;
              end else begin
                FRAME_ERR <= 1'b1;
                state     <= IDLE;
                shift     <= '0;
              end
            end
          end
          LEAD_SPACE: begin
            if (fall) begin
              if (in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                state   <= BIT_MARK;
                bit_cnt <= '0;
                shift   <= '0;
                rpt     <= 1'b0;
              end else if (in_window(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                state <= STOP_MARK;
                rpt   <= 1'b1;
              end else begin
                FRAME_ERR <= 1'b1;
                state     <= IDLE;
                shift     <= '0;
              end
            end
          end
          BIT_MARK: begin
            if (rise) begin
              if (in_window(width, BIT_MIN, BIT_MAX)) begin
                state <= BIT_SPACE;
              end else begin
                FRAME_ERR <= 1'b1;
                state     <= IDLE;
                shift     <= '0;
              end
            end
          end
          BIT_SPACE: begin
            if (fall) begin
              if (in_window(width, BIT_MIN, BIT_MAX) || in_window(width, ONE_MIN, ONE_MAX)) begin
                // LSB-first: each new bit enters at the top and moves down.
                shift <= {in_window(width, ONE_MIN, ONE_MAX), shift[31:1]};
                if (bit_cnt == 5'd31) begin
                  state <= STOP_MARK;
                end else begin
                  state   <= BIT_MARK;
                  bit_cnt <= bit_cnt + 5'd1;
                end
              end else begin
                FRAME_ERR <= 1'b1;
                state     <= IDLE;
                shift     <= '0;
              end
            end
          end
          STOP_MARK: begin
            if (rise) begin
              state <= IDLE;
              if (!in_window(width, BIT_MIN, BIT_MAX)) begin
                FRAME_ERR <= 1'b1;
                shift     <= '0;
              end else if (rpt) begin
                REPEAT <= 1'b1;
              end else if (CHECK_CMD_INV && ((shift[23:16] ^ shift[31:24]) != 8'hFF)) begin
                // Only the command byte is checked; extended-address remotes
                // legitimately break the address inversion.
                FRAME_ERR <= 1'b1;
                shift     <= '0;
              end else begin
                HEX_DATA   <= shift;
                DATA_VALID <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
